// File: rtl/dmx_frame_scheduler.sv
// dmx_frame_scheduler
//   Sequences one DMX512 frame after another: break, mark-after-break, start
//   code, then slot_count data bytes fetched from an external slot memory.
//   A new frame begins no sooner than FRAME_CYCLES cycles after the previous one.
//
// Ports
//   dmxclk_i        sole clock, rising edge
//   rst_i           synchronous active-high reset
//   enable_i        1 = transmit frames continuously
//   slot_count_i    data slots per frame (0 or >512 is treated as 512)
//   start_code_i    byte sent before slot 0
//   mem_rd_o        one-cycle read strobe to the slot memory
//   mem_addr_o      slot index being read
//   mem_data_i      slot byte, valid one cycle after mem_rd_o
//   tx_data_o       byte to the serializer
//   tx_valid_o      tx_data_o valid; held until tx_ready_i
//   tx_ready_i      serializer accept
//   line_break_o    line held in break
//   line_mark_o     mark-after-break
//   frame_start_o   pulse on the first break cycle
//   frame_done_o    pulse the cycle after the last slot is accepted
//   overrun_o       pulse when a frame ran longer than FRAME_CYCLES
//   busy_o          high outside IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable
// BREAK    | line held in break for BREAK_CYCLES
// MAB      | mark-after-break for MAB_CYCLES
// START    | start code offered to the serializer
// FETCH    | read strobe for the current slot
// WAIT_MEM | slot byte captured into tx_data
// SEND     | slot byte offered to the serializer
// GAP      | padding until the minimum frame period has elapsed

module dmx_frame_scheduler #(
    parameter int BREAK_CYCLES = 23,
    parameter int MAB_CYCLES   = 3,
    parameter int FRAME_CYCLES = 8334
) (
    input  logic       dmxclk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [9:0] slot_count_i,
    input  logic [7:0] start_code_i,
    output logic       mem_rd_o,
    output logic [8:0] mem_addr_o,
    input  logic [7:0] mem_data_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       line_break_o,
    output logic       line_mark_o,
    output logic       frame_start_o,
    output logic       frame_done_o,
    output logic       overrun_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_MAB,
        S_START,
        S_FETCH,
        S_WAIT_MEM,
        S_SEND,
        S_GAP
    } state_t;

    localparam logic [15:0] BRK_LOAD = 16'(BREAK_CYCLES - 1);
    localparam logic [15:0] MAB_LOAD = 16'(MAB_CYCLES - 1);
    localparam logic [15:0] GAP_TC   = 16'(FRAME_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] period_q, period_d;
    logic [8:0]  slot_idx_q, slot_idx_d;
    logic [9:0]  count_q, count_d;
    logic [7:0]  start_code_q, start_code_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        frame_done_q, frame_done_d;

    logic enter_break;
    logic last_slot;
    logic period_done;

    assign last_slot   = ({1'b0, slot_idx_q} == (count_q - 10'd1));
    assign period_done = (period_q >= GAP_TC);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        slot_idx_d   = slot_idx_q;
        count_d      = count_q;
        start_code_d = start_code_q;
        tx_data_d    = tx_data_q;
        frame_done_d = 1'b0;
        enter_break  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d     = S_BREAK;
                    enter_break = 1'b1;
                end
            end
            S_BREAK: begin
                if (phase_q == 16'd0) begin
                    state_d = S_MAB;
                    phase_d = MAB_LOAD;
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            S_MAB: begin
                if (phase_q == 16'd0) begin
                    state_d   = S_START;
                    tx_data_d = start_code_q;
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            S_START: begin
                if (tx_ready_i) begin
                    state_d    = S_FETCH;
                    slot_idx_d = 9'd0;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                tx_data_d = mem_data_i;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    if (last_slot) begin
                        state_d      = S_GAP;
                        frame_done_d = 1'b1;
                    end else begin
                        slot_idx_d = slot_idx_q + 9'd1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_GAP: begin
                // An overrunning frame arrives here already past the limit,
                // so GAP naturally lasts a single cycle in that case.
                if (period_done) begin
                    if (enable_i) begin
                        state_d     = S_BREAK;
                        enter_break = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_break) begin
            phase_d      = BRK_LOAD;
            start_code_d = start_code_i;
            count_d      = ((slot_count_i == 10'd0) || (slot_count_i > 10'd512)) ?
                           10'd512 : slot_count_i;
        end

        if (enter_break) begin
            period_d = 16'd0;
        end else if ((state_q == S_IDLE) || (period_q == 16'hFFFF)) begin
            period_d = period_q;
        end else begin
            period_d = period_q + 16'd1;
        end
    end

    always_ff @(posedge dmxclk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            phase_q      <= 16'd0;
            period_q     <= 16'd0;
            slot_idx_q   <= 9'd0;
            count_q      <= 10'd0;
            start_code_q <= 8'd0;
            tx_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            period_q     <= period_d;
            slot_idx_q   <= slot_idx_d;
            count_q      <= count_d;
            start_code_q <= start_code_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mem_rd_o      = (state_q == S_FETCH);
    assign mem_addr_o    = slot_idx_q;
    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = (state_q == S_START) || (state_q == S_SEND);
    assign line_break_o  = (state_q == S_BREAK);
    assign line_mark_o   = (state_q == S_MAB);
    // The break down-counter sits at its load value only on the first break cycle.
    assign frame_start_o = (state_q == S_BREAK) && (phase_q == BRK_LOAD);
    assign frame_done_o  = frame_done_q;
    // frame_done_q marks the first GAP cycle, where the entry count is judged.
    assign overrun_o     = (state_q == S_GAP) && frame_done_q && (period_q > GAP_TC);
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmx_frame_scheduler.sv
module tb_dmx_frame_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: default parameters
    logic       rst_a, en_a, tx_ready_a;
    logic [9:0] sc_a;
    logic [7:0] code_a, mem_data_a, tx_data_a;
    logic       mem_rd_a, tx_valid_a, brk_a, mark_a, fs_a, fd_a, ovr_a, busy_a;
    logic [8:0] mem_addr_a;

    // DUT B: short minimum frame period to force overrun
    logic       rst_b, en_b, tx_ready_b;
    logic [9:0] sc_b;
    logic [7:0] code_b, mem_data_b, tx_data_b;
    logic       mem_rd_b, tx_valid_b, brk_b, mark_b, fs_b, fd_b, ovr_b, busy_b;
    logic [8:0] mem_addr_b;

    dmx_frame_scheduler dut_a (
        .dmxclk_i(clk), .rst_i(rst_a), .enable_i(en_a), .slot_count_i(sc_a),
        .start_code_i(code_a), .mem_rd_o(mem_rd_a), .mem_addr_o(mem_addr_a),
        .mem_data_i(mem_data_a), .tx_data_o(tx_data_a), .tx_valid_o(tx_valid_a),
        .tx_ready_i(tx_ready_a), .line_break_o(brk_a), .line_mark_o(mark_a),
        .frame_start_o(fs_a), .frame_done_o(fd_a), .overrun_o(ovr_a), .busy_o(busy_a)
    );

    dmx_frame_scheduler #(.FRAME_CYCLES(50)) dut_b (
        .dmxclk_i(clk), .rst_i(rst_b), .enable_i(en_b), .slot_count_i(sc_b),
        .start_code_i(code_b), .mem_rd_o(mem_rd_b), .mem_addr_o(mem_addr_b),
        .mem_data_i(mem_data_b), .tx_data_o(tx_data_b), .tx_valid_o(tx_valid_b),
        .tx_ready_i(tx_ready_b), .line_break_o(brk_b), .line_mark_o(mark_b),
        .frame_start_o(fs_b), .frame_done_o(fd_b), .overrun_o(ovr_b), .busy_o(busy_b)
    );

    // Slot memory: data = address + 0x10, one cycle after the read strobe
    initial begin mem_data_a = 8'h00; mem_data_b = 8'h00; end
    always @(posedge clk) if (mem_rd_a) mem_data_a <= 8'(mem_addr_a + 9'h10);
    always @(posedge clk) if (mem_rd_b) mem_data_b <= 8'(mem_addr_b + 9'h10);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int fs_t_a[$];
    int acc_t_a[$];
    int fs_cnt_a = 0, fd_cnt_a = 0, ovr_cnt_a = 0, stall_a = 0;
    int brk_first_a = -1, brk_last_a = -1, mark_first_a = -1, mark_last_a = -1;
    logic       pv_valid_a = 1'b0, pv_ready_a = 1'b0;
    logic [7:0] pv_data_a = 8'h00;

    int fs_cnt_b = 0, fd_cnt_b = 0, ovr_cnt_b = 0, acc_cnt_b = 0;
    logic pv_ovr_b = 1'b0, pv_en_b = 1'b0;

    // Monitor A: scoreboard, handshake hold, phase timing
    always @(negedge clk) begin
        if (rst_a) begin
            pv_valid_a = 1'b0;
        end else begin
            check("excl_a", 32'($onehot0({mem_rd_a, tx_valid_a, brk_a, mark_a})), 1);
            if (fs_a) begin fs_cnt_a++; fs_t_a.push_back(cyc); end
            if (brk_a && fs_cnt_a == 1) begin
                if (brk_first_a < 0) brk_first_a = cyc;
                brk_last_a = cyc;
            end
            if (mark_a && fs_cnt_a == 1) begin
                if (mark_first_a < 0) mark_first_a = cyc;
                mark_last_a = cyc;
            end
            if (fd_a) fd_cnt_a++;
            if (ovr_a) ovr_cnt_a++;
            if (pv_valid_a && !pv_ready_a) begin
                check("hold_valid_a", 32'(tx_valid_a), 1);
                check("hold_data_a", 32'(tx_data_a), 32'(pv_data_a));
            end
            if (tx_valid_a && !tx_ready_a) stall_a++;
            if (tx_valid_a && tx_ready_a) begin
                acc_t_a.push_back(cyc);
                if (exp_a.size() == 0) begin
                    tests++; fails++;
                    $error("FAIL extra_byte_a observed=%0h expected=none", tx_data_a);
                end else begin
                    check("byte_a", 32'(tx_data_a), 32'(exp_a.pop_front()));
                end
            end
            pv_valid_a = tx_valid_a;
            pv_ready_a = tx_ready_a;
            pv_data_a  = tx_data_a;
        end
    end

    // Monitor B: scoreboard and break-right-after-overrun
    always @(negedge clk) begin
        if (!rst_b) begin
            if (fs_b) fs_cnt_b++;
            if (fd_b) fd_cnt_b++;
            if (ovr_b) begin
                ovr_cnt_b++;
                check("ovr_with_done_b", 32'(fd_b), 1);
            end
            if (pv_ovr_b && pv_en_b) check("break_after_gap_b", 32'(fs_b), 1);
            if (tx_valid_b && tx_ready_b) begin
                acc_cnt_b++;
                if (exp_b.size() == 0) begin
                    tests++; fails++;
                    $error("FAIL extra_byte_b observed=%0h expected=none", tx_data_b);
                end else begin
                    check("byte_b", 32'(tx_data_b), 32'(exp_b.pop_front()));
                end
            end
            pv_ovr_b = ovr_b;
            pv_en_b  = en_b;
        end
    end

    initial begin
        int base;
        int n;
        logic [7:0] v8;

        rst_a = 1'b1; en_a = 1'b0; tx_ready_a = 1'b1; sc_a = 10'd3; code_a = 8'hA5;
        rst_b = 1'b1; en_b = 1'b0; tx_ready_b = 1'b1; sc_b = 10'd0; code_b = 8'h55;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_mem_rd", 32'(mem_rd_a), 0);
        check("rst_mem_addr", 32'(mem_addr_a), 0);
        check("rst_tx_data", 32'(tx_data_a), 0);
        check("rst_tx_valid", 32'(tx_valid_a), 0);
        check("rst_break", 32'(brk_a), 0);
        check("rst_mark", 32'(mark_a), 0);
        check("rst_fstart", 32'(fs_a), 0);
        check("rst_fdone", 32'(fd_a), 0);
        check("rst_overrun", 32'(ovr_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_all_b", 32'({mem_rd_b, mem_addr_b, tx_data_b, tx_valid_b, brk_b,
                                mark_b, fs_b, fd_b, ovr_b, busy_b}), 0);

        // Reset has priority over enable
        en_a = 1'b1;
        @(posedge clk); #1;
        check("rst_prio_busy", 32'(busy_a), 0);
        en_a = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        check("idle_no_enable", 32'(busy_a), 0);

        // Frame 1: 3 slots; frame 2 latches the values changed mid-frame-1
        exp_a.push_back(8'hA5); exp_a.push_back(8'h10);
        exp_a.push_back(8'h11); exp_a.push_back(8'h12);
        exp_a.push_back(8'h3C); exp_a.push_back(8'h10); exp_a.push_back(8'h11);

        base = cyc;
        en_a = 1'b1;
        n = 0;
        while (!fs_a && n < 10) begin @(posedge clk); #1; n++; end
        check("fs1_time", 32'(cyc - base), 1);
        sc_a = 10'd2; code_a = 8'h3C;

        n = 0;
        while (!fd_a && n < 100) begin @(posedge clk); #1; n++; end
        check("fd1_seen", 32'(fd_a), 1);
        check("brk_first", 32'(brk_first_a - base), 1);
        check("brk_last", 32'(brk_last_a - base), 23);
        check("mark_first", 32'(mark_first_a - base), 24);
        check("mark_last", 32'(mark_last_a - base), 26);
        check("f1_bytes", 32'(acc_t_a.size()), 4);
        if (acc_t_a.size() >= 4) begin
            check("start_code_time", 32'(acc_t_a[0] - base), 27);
            for (int i = 1; i < 4; i++) check("byte_spacing", 32'(acc_t_a[i] - acc_t_a[i-1]), 3);
        end

        n = 0;
        while (fs_cnt_a < 2 && n < 9000) begin @(posedge clk); #1; n++; end
        check("fs2_seen", 32'(fs_cnt_a), 2);
        if (fs_t_a.size() >= 2) check("frame_period", 32'(fs_t_a[1] - fs_t_a[0]), 8334);
        check("fd_once", 32'(fd_cnt_a), 1);
        check("no_overrun_a", 32'(ovr_cnt_a), 0);

        // Drop enable during MAB of frame 2
        n = 0;
        while (!mark_a && n < 40) begin @(posedge clk); #1; n++; end
        check("mab2_seen", 32'(mark_a), 1);
        en_a = 1'b0;

        // Backpressure on slot 1: five stalled SEND cycles
        n = 0;
        while (!(mem_rd_a && mem_addr_a == 9'd1) && n < 60) begin @(posedge clk); #1; n++; end
        check("fetch_slot1", 32'(mem_rd_a && mem_addr_a == 9'd1), 1);
        tx_ready_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        tx_ready_a = 1'b1;

        n = 0;
        while (!fd_a && n < 60) begin @(posedge clk); #1; n++; end
        check("fd2_seen", 32'(fd_a), 1);
        check("stall_cycles", 32'(stall_a), 5);
        n = 0;
        while (busy_a && n < 9000) begin @(posedge clk); #1; n++; end
        repeat (100) @(posedge clk);
        #1;
        check("idle_after_disable", 32'(busy_a), 0);
        check("no_extra_frame", 32'(fs_cnt_a), 2);
        check("fd_twice", 32'(fd_cnt_a), 2);
        check("queue_a_empty", 32'(exp_a.size()), 0);

        // Reset while a slot byte is stalled in SEND
        sc_a = 10'd3; code_a = 8'h77;
        exp_a.push_back(8'h77);
        en_a = 1'b1;
        n = 0;
        while (!mem_rd_a && n < 60) begin @(posedge clk); #1; n++; end
        tx_ready_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("send_before_rst", 32'(tx_valid_a && busy_a), 1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", 32'({mem_rd_a, mem_addr_a, tx_data_a, tx_valid_a, brk_a,
                                      mark_a, fs_a, fd_a, ovr_a}), 0);
        check("rst_mid_busy", 32'(busy_a), 0);
        rst_a = 1'b0; en_a = 1'b0; tx_ready_a = 1'b1;
        check("queue_a_after_rst", 32'(exp_a.size()), 0);

        // DUT B: slot_count 0 -> 512 slots, overrun every frame
        for (int f = 0; f < 2; f++) begin
            exp_b.push_back(8'h55);
            for (int i = 0; i < 512; i++) begin
                v8 = 8'(i + 16);
                exp_b.push_back(v8);
            end
        end
        en_b = 1'b1;
        n = 0;
        while (fs_cnt_b < 2 && n < 3000) begin @(posedge clk); #1; n++; end
        check("b_fs2_seen", 32'(fs_cnt_b), 2);
        check("b_ovr_first", 32'(ovr_cnt_b), 1);
        en_b = 1'b0;
        n = 0;
        while (fd_cnt_b < 2 && n < 3000) begin @(posedge clk); #1; n++; end
        n = 0;
        while (busy_b && n < 100) begin @(posedge clk); #1; n++; end
        check("b_idle", 32'(busy_b), 0);
        check("b_fd_count", 32'(fd_cnt_b), 2);
        check("b_ovr_count", 32'(ovr_cnt_b), 2);
        check("b_fs_count", 32'(fs_cnt_b), 2);
        check("b_bytes", 32'(acc_cnt_b), 1026);
        check("b_queue_empty", 32'(exp_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
